crc8_frame_checker: RTL and testbench
=====================================

// Module: crc8_frame_checker
// PURPOSE
// - Receive side of the CRC-8 link: accepts a byte stream framed by data_last_i; the final byte of each frame is the
//   transmitted CRC-8. Recomputes CRC-8 over the whole frame, payload plus CRC byte, and checks the residue against 0.
// - Reports pass/fail, length errors and the received/calculated CRC for one cycle per frame.
// - Sits between the byte deserialiser and the command decoder.
// PARAMETERS
// - POLYNOMIAL  8'h07  CRC-8 generator polynomial, MSB-first, no reflection, no final XOR.
// - INITIAL     8'h00  CRC register value at frame start.
// - MAX_LEN     64     Maximum frame length in bytes, CRC byte included; must be >= 2.
// PORTS
// - clk_i        in   1      Clock; all logic on rising edge.
// - rst_i        in   1      Reset, asynchronous, active-high.
// - data_i       in   8      Received byte.
// - data_valid_i in   1      data_i valid; byte accepted when data_valid_i && ready_o.
// - data_last_i  in   1      Qualifies the accepted byte as the last (CRC) byte of the frame.
// - ready_o      out  1      High when a byte can be accepted.
// - frame_done_o out  1      One-cycle pulse: frame result valid.
// - frame_ok_o   out  1      Valid with frame_done_o: residue==0 and 2<=length<=MAX_LEN.
// - crc_err_o    out  1      Valid with frame_done_o: residue!=0 and no length error.
// - len_err_o    out  1      Valid with frame_done_o: length<2 or length>MAX_LEN.
// - frame_len_o  out  LW     Bytes accepted, CRC included; LW=$clog2(MAX_LEN+1); saturates at MAX_LEN.
// - calc_crc_o   out  8      CRC over the frame excluding the last byte.
// - rx_crc_o     out  8      Last byte of the frame.
// - good_cnt_o   out  16     Frames passed (optional feature).
// - bad_cnt_o    out  16     Frames failed (optional feature).
// BEHAVIOUR
// - CRC update: per accepted byte, 8 MSB-first shift/XOR steps, computed combinationally in one cycle. No table.
//   crc_next = f(crc ^ data_i). crc_prev holds the value before the latest byte.
// - FSM states: IDLE, RECV, DISCARD, CHECK.
//   - IDLE: ready_o=1. On an accepted byte: crc <= f(INITIAL^data_i), len <= 1.
//     Goes to CHECK if data_last_i, else to RECV.
//   - RECV: ready_o=1. On an accepted byte: crc updates, len increments.
//     If data_last_i: go to CHECK.
//     Else if len == MAX_LEN before this byte: go to DISCARD, len held at MAX_LEN, overflow flag set.
//   - DISCARD: ready_o=1. Bytes are consumed and ignored; the CRC is frozen. On an accepted byte with data_last_i,
//     go to CHECK with len_err.
//   - CHECK: exactly one cycle, then IDLE. ready_o=0; data_valid_i is ignored and no byte is lost or counted.
//     frame_done_o=1, and exactly one of ok/crc_err/len_err is 1.
// - Latency: the result appears in the cycle after the last byte is accepted. Back-to-back frames lose one cycle (CHECK).
// - Length rule: len==1 (single-byte frame) gives len_err, even when its residue is 0. Overflow gives len_err.
//   len_err takes priority over crc_err.
// - frame_len_o, calc_crc_o and rx_crc_o are registered and hold their value until the next CHECK.
//   Outside CHECK, frame_ok_o, crc_err_o and len_err_o are 0.
// - Reset values: ready_o=1, frame_done_o/frame_ok_o/crc_err_o/len_err_o=0, frame_len_o=0, calc_crc_o=rx_crc_o=0,
//   counters=0, state=IDLE.
// - Reset mid-frame: the partial frame is abandoned with no frame_done_o pulse; the first byte after reset starts a
//   new frame.
// CONFIGURATION
// - CRC8_CHECK_STATS_EN defined: good_cnt_o and bad_cnt_o are 16-bit counters.
//   - They increment in CHECK on ok and on (crc_err|len_err) respectively.
//   - They saturate at 16'hFFFF and clear only on rst_i.
// - CRC8_CHECK_STATS_EN undefined: good_cnt_o and bad_cnt_o are tied to 16'h0000, no counter flops;
//   the port list is unchanged.
// TESTING
// - Frame {0x01,0x07}: next cycle frame_done_o=1, frame_ok_o=1, frame_len_o=2, calc_crc_o=0x07, rx_crc_o=0x07.
// - Frame "123456789" (0x31..0x39) then 0xF4: frame_ok_o=1, len=10. Same frame with last byte 0xF5: crc_err_o=1,
//   calc_crc_o=0xF4, rx_crc_o=0xF5.
// - Single byte 0x00 with data_last_i: len_err_o=1, frame_ok_o=0, frame_len_o=1.
// - MAX_LEN=4, 7 bytes with last on the 7th: len_err_o=1, frame_len_o=4, ready_o=1 throughout DISCARD.
// - Back-to-back frames with data_valid_i held high: ready_o=0 for exactly the CHECK cycle; the byte presented then
//   is accepted the cycle after, and both results are correct.
// - Reset asserted after 3 bytes: no frame_done_o; the next {0x01,0x07} frame passes.
//   With stats enabled: good=1, bad=0 after that frame.

Source files
------------

// File: rtl/crc8_frame_checker.sv
// CRC-8 receive-side frame checker: recomputes CRC over payload plus CRC byte and checks for a zero residue.
// Optional pass/fail counters are built when CRC8_CHECK_STATS_EN is defined.
module crc8_frame_checker #(
  parameter logic [7:0]  POLYNOMIAL = 8'h07,
  parameter logic [7:0]  INITIAL    = 8'h00,
  parameter int unsigned MAX_LEN    = 64,
  localparam int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    data_i,
  input  logic          data_valid_i,
  input  logic          data_last_i,
  output logic          ready_o,
  output logic          frame_done_o,
  output logic          frame_ok_o,
  output logic          crc_err_o,
  output logic          len_err_o,
  output logic [LW-1:0] frame_len_o,
  output logic [7:0]    calc_crc_o,
  output logic [7:0]    rx_crc_o,
  output logic [15:0]   good_cnt_o,
  output logic [15:0]   bad_cnt_o
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, CHECK} state_t;

  state_t        state;
  logic [7:0]    crc;
  logic [LW-1:0] len;

  logic [7:0]    crc_base;
  logic [7:0]    crc_next;
  logic [LW-1:0] len_next;
  logic          accept;
  logic          len_max;
  logic          overflow;
  logic          len_bad;

  function automatic logic [7:0] crc_step(input logic [7:0] c_in);
    logic [7:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
    return c;
  endfunction

  // crc holds the value before the current byte, so crc_base doubles as calc_crc for a last byte
  always_comb begin
    crc_base = (state == IDLE) ? INITIAL : crc;
    crc_next = crc_step(crc_base ^ data_i);
    accept   = data_valid_i && ready_o;
    len_max  = (len == LW'(MAX_LEN));
    len_next = len;
    overflow = 1'b0;
    case (state)
      IDLE:    len_next = LW'(1);
      RECV: begin
        len_next = len_max ? len : len + LW'(1);
        overflow = len_max;
      end
      DISCARD: overflow = 1'b1;
      default: len_next = len;
    endcase
    len_bad = overflow || (len_next < LW'(2));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      crc          <= '0;
      len          <= '0;
      ready_o      <= 1'b1;
      frame_done_o <= 1'b0;
      frame_ok_o   <= 1'b0;
      crc_err_o    <= 1'b0;
      len_err_o    <= 1'b0;
      frame_len_o  <= '0;
      calc_crc_o   <= '0;
      rx_crc_o     <= '0;
    end else begin
      frame_done_o <= 1'b0;
      frame_ok_o   <= 1'b0;
      crc_err_o    <= 1'b0;
      len_err_o    <= 1'b0;
      case (state)
        CHECK: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          if (accept) begin
            if (state != DISCARD) crc <= crc_next;
            len <= len_next;
            if (data_last_i) begin
              state        <= CHECK;
              ready_o      <= 1'b0;
              frame_done_o <= 1'b1;
              frame_ok_o   <= !len_bad && (crc_next == 8'h00);
              crc_err_o    <= !len_bad && (crc_next != 8'h00);
              len_err_o    <= len_bad;
              frame_len_o  <= len_next;
              calc_crc_o   <= crc_base;
              rx_crc_o     <= data_i;
            end else if (state == RECV && len_max) begin
              state <= DISCARD;
            end else if (state == IDLE) begin
              state <= RECV;
            end
          end
        end
      endcase
    end
  end

`ifdef CRC8_CHECK_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      good_cnt_o <= '0;
      bad_cnt_o  <= '0;
    end else if (state == CHECK) begin
      if (frame_ok_o && good_cnt_o != '1) good_cnt_o <= good_cnt_o + 16'd1;
      if ((crc_err_o || len_err_o) && bad_cnt_o != '1) bad_cnt_o <= bad_cnt_o + 16'd1;
    end
  end
`else
  assign good_cnt_o = '0;
  assign bad_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed self-checking bench for crc8_frame_checker; a second instance with MAX_LEN=4 covers length limits.
module tb_crc8_frame_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = '0;
  logic        valid = 1'b0;
  logic        last = 1'b0;

  logic        ready, done, ok, crc_err, len_err;
  logic [6:0]  flen;
  logic [7:0]  calc, rxc;
  logic [15:0] good, bad;

  logic        ready4, done4, ok4, crc_err4, len_err4;
  logic [2:0]  flen4;
  logic [7:0]  calc4, rxc4;
  logic [15:0] good4, bad4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  crc8_frame_checker dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .data_valid_i(valid), .data_last_i(last),
    .ready_o(ready), .frame_done_o(done), .frame_ok_o(ok), .crc_err_o(crc_err), .len_err_o(len_err),
    .frame_len_o(flen), .calc_crc_o(calc), .rx_crc_o(rxc), .good_cnt_o(good), .bad_cnt_o(bad)
  );

  crc8_frame_checker #(.MAX_LEN(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .data_valid_i(valid), .data_last_i(last),
    .ready_o(ready4), .frame_done_o(done4), .frame_ok_o(ok4), .crc_err_o(crc_err4), .len_err_o(len_err4),
    .frame_len_o(flen4), .calc_crc_o(calc4), .rx_crc_o(rxc4), .good_cnt_o(good4), .bad_cnt_o(bad4)
  );

  // Presents one byte from a negedge and returns at posedge+1 once it has been accepted.
  task automatic send(input logic [7:0] d, input logic l, output bit stalled);
    int unsigned n;
    n = 0;
    stalled = 1'b0;
    @(negedge clk);
    data = d; valid = 1'b1; last = l;
    while (!ready && n < 8) begin
      stalled = 1'b1;
      n++;
      @(negedge clk);
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL send_timeout ready stuck at %b, required 1", ready);
    end
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, done, ok, crc_err, len_err} !== 5'b10000) begin errors++;
      $display("FAIL reset_flags got %b required 10000", {ready, done, ok, crc_err, len_err}); end
    checks++;
    if ({flen, calc, rxc, good, bad} !== '0) begin errors++;
      $display("FAIL reset_values len %h calc %h rx %h good %h bad %h required all 0", flen, calc, rxc, good, bad); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    bit s;
    send(8'h01, 1'b0, s);
    send(8'h07, 1'b1, s);
    checks++;
    if ({done, ok, crc_err, len_err, ready} !== 5'b11000) begin errors++;
      $display("FAIL basic_flags got %b required 11000", {done, ok, crc_err, len_err, ready}); end
    checks++;
    if ({flen, calc, rxc} !== {7'd2, 8'h07, 8'h07}) begin errors++;
      $display("FAIL basic_data len %0d calc %h rx %h required 2 07 07", flen, calc, rxc); end
    idle(1);
    checks++;
    if ({done, ok, ready, flen, calc} !== {3'b001, 7'd2, 8'h07}) begin errors++;
      $display("FAIL basic_hold done %b ok %b ready %b len %0d calc %h required 0 0 1 2 07",
               done, ok, ready, flen, calc); end
  endtask

  task automatic test_check_string(input logic [7:0] crc_byte, input bit expect_ok);
    logic [7:0] msg [9];
    bit s;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    idle(2);
    for (int i = 0; i < 9; i++) send(msg[i], 1'b0, s);
    send(crc_byte, 1'b1, s);
    checks++;
    if ({done, ok, crc_err, len_err} !== {1'b1, expect_ok, !expect_ok, 1'b0}) begin errors++;
      $display("FAIL string_flags rx %h got %b required %b", crc_byte, {done, ok, crc_err, len_err},
               {1'b1, expect_ok, !expect_ok, 1'b0}); end
    checks++;
    if ({flen, calc, rxc} !== {7'd10, 8'hF4, crc_byte}) begin errors++;
      $display("FAIL string_data len %0d calc %h rx %h required 10 f4 %h", flen, calc, rxc, crc_byte); end
  endtask

  task automatic test_single_byte;
    bit s;
    idle(2);
    send(8'h00, 1'b1, s);
    checks++;
    if ({done, ok, crc_err, len_err, flen} !== {4'b1001, 7'd1}) begin errors++;
      $display("FAIL single_byte got flags %b len %0d required 1001 1", {done, ok, crc_err, len_err}, flen); end
  endtask

  task automatic test_max_len;
    bit s;
    bit any_stall;
    logic [7:0] f4 [4];
    f4 = '{8'h01, 8'h00, 8'h00, 8'h6B};
    idle(2);
    for (int i = 0; i < 4; i++) send(f4[i], i == 3, s);
    checks++;
    if ({done4, ok4, crc_err4, len_err4, flen4} !== {4'b1100, 3'd4}) begin errors++;
      $display("FAIL maxlen_exact got flags %b len %0d required 1100 4", {done4, ok4, crc_err4, len_err4}, flen4); end
    idle(2);
    for (int i = 0; i < 5; i++) send(i == 0 ? 8'h01 : 8'h00, i == 4, s);
    checks++;
    if ({done4, ok4, crc_err4, len_err4, flen4} !== {4'b1001, 3'd4}) begin errors++;
      $display("FAIL maxlen_plus1 got flags %b len %0d required 1001 4", {done4, ok4, crc_err4, len_err4}, flen4); end
    idle(2);
    any_stall = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(8'h10 + 8'(i), i == 6, s);
      any_stall |= s;
    end
    checks++;
    if (any_stall !== 1'b0) begin errors++;
      $display("FAIL discard_ready stalled %b required 0", any_stall); end
    checks++;
    if ({done4, ok4, crc_err4, len_err4, flen4} !== {4'b1001, 3'd4}) begin errors++;
      $display("FAIL discard_result got flags %b len %0d required 1001 4", {done4, ok4, crc_err4, len_err4}, flen4); end
  endtask

  task automatic test_back_to_back;
    bit s;
    idle(2);
    send(8'h01, 1'b0, s);
    send(8'h07, 1'b1, s);
    valid = 1'b1; data = 8'h01; last = 1'b0;
    checks++;
    if ({done, ok, ready} !== 3'b110) begin errors++;
      $display("FAIL b2b_check done %b ok %b ready %b required 1 1 0", done, ok, ready); end
    @(posedge clk); #1;
    checks++;
    if ({done, ready} !== 2'b01) begin errors++;
      $display("FAIL b2b_after done %b ready %b required 0 1", done, ready); end
    @(posedge clk); #1;
    data = 8'h07; last = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
    checks++;
    if ({done, ok, crc_err, len_err, flen, calc} !== {4'b1100, 7'd2, 8'h07}) begin errors++;
      $display("FAIL b2b_second flags %b len %0d calc %h required 1100 2 07",
               {done, ok, crc_err, len_err}, flen, calc); end
  endtask

  task automatic test_reset_mid_frame;
    bit s;
    bit seen;
    idle(2);
    send(8'h01, 1'b0, s);
    send(8'h02, 1'b0, s);
    send(8'h03, 1'b0, s);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({flen, ready} !== {7'd0, 1'b1}) begin errors++;
      $display("FAIL async_reset len %0d ready %b required 0 1", flen, ready); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= done; end
    checks++;
    if (seen !== 1'b0) begin errors++;
      $display("FAIL reset_no_done saw done %b required 0", seen); end
    send(8'h01, 1'b0, s);
    send(8'h07, 1'b1, s);
    checks++;
    if ({done, ok, flen} !== {2'b11, 7'd2}) begin errors++;
      $display("FAIL reset_next_frame done %b ok %b len %0d required 1 1 2", done, ok, flen); end
    idle(1);
`ifdef CRC8_CHECK_STATS_EN
    checks++;
    if ({good, bad} !== {16'd1, 16'd0}) begin errors++;
      $display("FAIL stats good %0d bad %0d required 1 0", good, bad); end
`else
    checks++;
    if ({good, bad} !== 32'd0) begin errors++;
      $display("FAIL stats_tied good %0d bad %0d required 0 0", good, bad); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_check_string(8'hF4, 1'b1);
    test_check_string(8'hF5, 1'b0);
    test_single_byte();
    test_max_len();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation time exceeded");
    $fatal(1);
  end
endmodule
